axi_cpu_master: RTL and testbench

//  AXI4 initiator bridging one CPU-side memory port (IM or DM) onto the AXI4 bus, driving

---
 rtl/axi_cpu_master_pkg.sv | 41 ++++
 rtl/axi_cpu_master_if.sv | 61 ++++++
 rtl/axi_cpu_master.sv | 132 +++++++++++++
 tb/tb_axi_cpu_master.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cpu_master_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : axi_cpu_master_pkg
//  Description : Shared AXI4 widths, fixed field encodings and bridge FSM states
//  Revision    : 1.0 - initial release
// =============================================================================
package axi_cpu_master_pkg;

    localparam int AXI_ID_BITS    = 4;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_DATA_BITS  = 32;
    localparam int AXI_STRB_BITS  = 4;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;
    localparam int AXI_RESP_BITS  = 2;

    localparam logic [AXI_BURST_BITS-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_RESP_BITS-1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [AXI_LEN_BITS-1:0]   AXI_LEN_ONE    = '0;

    localparam logic [AXI_SIZE_BITS-1:0]  AXI_SIZE_BYTE  = 3'd0;
    localparam logic [AXI_SIZE_BITS-1:0]  AXI_SIZE_HALF  = 3'd1;
    localparam logic [AXI_SIZE_BITS-1:0]  AXI_SIZE_WORD  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    function automatic logic resp_is_err(input logic [AXI_RESP_BITS-1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_cpu_master_if.sv
`default_nettype none
// =============================================================================
//  Module      : axi_cpu_master_if
//  Description : AXI4 five-channel bundle with master and slave views
//  Revision    : 1.0 - initial release
// =============================================================================
interface axi_cpu_master_if;
    import axi_cpu_master_pkg::*;

    logic [AXI_ID_BITS-1:0]    AWID;
    logic [AXI_ADDR_BITS-1:0]  AWADDR;
    logic [AXI_LEN_BITS-1:0]   AWLEN;
    logic [AXI_SIZE_BITS-1:0]  AWSIZE;
    logic [AXI_BURST_BITS-1:0] AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;

    logic [AXI_DATA_BITS-1:0]  WDATA;
    logic [AXI_STRB_BITS-1:0]  WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;

    logic [AXI_ID_BITS-1:0]    BID;
    logic [AXI_RESP_BITS-1:0]  BRESP;
    logic                      BVALID;
    logic                      BREADY;

    logic [AXI_ID_BITS-1:0]    ARID;
    logic [AXI_ADDR_BITS-1:0]  ARADDR;
    logic [AXI_LEN_BITS-1:0]   ARLEN;
    logic [AXI_SIZE_BITS-1:0]  ARSIZE;
    logic [AXI_BURST_BITS-1:0] ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;

    logic [AXI_ID_BITS-1:0]    RID;
    logic [AXI_DATA_BITS-1:0]  RDATA;
    logic [AXI_RESP_BITS-1:0]  RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );

endinterface
`default_nettype wire

// File: rtl/axi_cpu_master.sv
`default_nettype none
// =============================================================================
//  Module      : axi_cpu_master
//  Description : CPU memory port to AXI4 initiator, one single-beat transfer
//                in flight at a time
//  Revision    : 1.0 - initial release
// =============================================================================
module axi_cpu_master
    import axi_cpu_master_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  wire logic                      ACLK,
    input  wire logic                      ARESETn,

    input  wire logic                      req_valid,
    output logic                           req_ready,
    input  wire logic                      req_write,
    input  wire logic [AXI_ADDR_BITS-1:0]  req_addr,
    input  wire logic [AXI_SIZE_BITS-1:0]  req_size,
    input  wire logic [AXI_DATA_BITS-1:0]  req_wdata,
    input  wire logic [AXI_STRB_BITS-1:0]  req_wstrb,

    output logic                           resp_valid,
    output logic [AXI_DATA_BITS-1:0]       resp_rdata,
    output logic                           resp_err,
    output logic                           busy,

    axi_cpu_master_if.master               m_axi
);

    state_e                     r_state;
    state_e                     w_state_nxt;

    logic [AXI_ADDR_BITS-1:0]   r_addr;
    logic [AXI_SIZE_BITS-1:0]   r_size;
    logic [AXI_DATA_BITS-1:0]   r_wdata;
    logic [AXI_STRB_BITS-1:0]   r_wstrb;
    logic [AXI_DATA_BITS-1:0]   r_rdata;
    logic                       r_err;

    logic                       w_accept;
    logic                       w_unused;

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    // Single outstanding transaction, so response IDs carry no information.
    assign w_unused = ^{m_axi.RID, m_axi.BID};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = req_write ? ST_AW : ST_AR;
                end
            end
            ST_AR:   if (m_axi.ARREADY) w_state_nxt = ST_R;
            ST_R:    if (m_axi.RVALID && m_axi.RLAST) w_state_nxt = ST_DONE;
            ST_AW:   if (m_axi.AWREADY) w_state_nxt = ST_W;
            ST_W:    if (m_axi.WREADY) w_state_nxt = ST_B;
            ST_B:    if (m_axi.BVALID) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Payload registers: every AXI field is sourced from here so it stays
    // stable while VALID waits for READY, regardless of what the core does.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_size  <= req_size;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                r_err   <= 1'b0;
            end
            if ((r_state == ST_R) && m_axi.RVALID) begin
                r_rdata <= m_axi.RDATA;
                r_err   <= resp_is_err(m_axi.RRESP);
            end
            if ((r_state == ST_B) && m_axi.BVALID) begin
                r_err   <= resp_is_err(m_axi.BRESP);
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = (r_state == ST_DONE);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign m_axi.ARID    = MASTER_ID;
    assign m_axi.ARADDR  = r_addr;
    assign m_axi.ARLEN   = AXI_LEN_ONE;
    assign m_axi.ARSIZE  = r_size;
    assign m_axi.ARBURST = AXI_BURST_INCR;
    assign m_axi.ARVALID = (r_state == ST_AR);
    assign m_axi.RREADY  = (r_state == ST_R);

    assign m_axi.AWID    = MASTER_ID;
    assign m_axi.AWADDR  = r_addr;
    assign m_axi.AWLEN   = AXI_LEN_ONE;
    assign m_axi.AWSIZE  = r_size;
    assign m_axi.AWBURST = AXI_BURST_INCR;
    assign m_axi.AWVALID = (r_state == ST_AW);

    assign m_axi.WDATA   = r_wdata;
    assign m_axi.WSTRB   = r_wstrb;
    assign m_axi.WLAST   = 1'b1;
    assign m_axi.WVALID  = (r_state == ST_W);
    assign m_axi.BREADY  = (r_state == ST_B);

endmodule
`default_nettype wire

// File: tb/tb_axi_cpu_master.sv
`default_nettype none
// =============================================================================
//  Module      : tb_axi_cpu_master
//  Description : Randomized scoreboard bench with a responsive SRAM-like slave
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_axi_cpu_master;
    import axi_cpu_master_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_size = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    always #5 ACLK = ~ACLK;

    axi_cpu_master_if bus();

    axi_cpu_master #(.MASTER_ID(4'd0)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .m_axi(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem   [0:1023];
    logic [31:0] slave_mem [0:1023];
    logic [31:0] last_rdata = '0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [2:0]  cur_size = '0;
    logic [3:0]  cur_wstrb = '0;
    int          ar_stall = 0;
    bit          w_block = 1'b0;

    // Upper half of the 4 KiB window decodes as a slave error region.
    function automatic bit is_err(input logic [31:0] a);
        return (a >= 32'h800);
    endfunction

    // ---------------- scoreboard monitor ----------------
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                prev = 1'b0;
            end else begin
                if (resp_valid) begin
                    chk("resp_pulse_1cycle", {31'b0, prev}, 32'd0);
                    if (sbq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_resp: got resp_valid=1 required no response");
                    end else begin
                        e = sbq.pop_front();
                        chk(e.wr ? "wr_rdata_hold" : "rd_data", resp_rdata, e.rdata);
                        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    end
                end
                prev = resp_valid;
            end
        end
    end

    // ---------------- slave model (decides at negedge for the next posedge) ----------------
    initial begin
        bit          prev_ar_wait, prev_aw_wait, prev_w_wait, rd_pend, r_drop, b_drop, aw_done, w_done;
        logic [31:0] prev_araddr, prev_awaddr, prev_wdata, rd_addr, wr_addr;
        int          rd_delay, rd_beats, b_delay;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                prev_ar_wait = 0; prev_aw_wait = 0; prev_w_wait = 0; rd_pend = 0; r_drop = 0;
                b_drop = 0; aw_done = 0; w_done = 0; rd_beats = 0; rd_delay = 0; b_delay = 0;
                bus.ARREADY = 0; bus.AWREADY = 0; bus.WREADY = 0; bus.RVALID = 0; bus.BVALID = 0;
                bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0; bus.RLAST = 0; bus.BID = '0; bus.BRESP = '0;
                continue;
            end
            // R channel, possibly with a leading RLAST=0 junk beat
            if (r_drop) begin
                bus.RVALID = 0; r_drop = 0;
                if (rd_beats == 0) rd_pend = 0;
            end
            if (!bus.RVALID && rd_pend && rd_beats > 0) begin
                if (rd_delay > 0) rd_delay--;
                else begin
                    bus.RVALID = 1; bus.RLAST = (rd_beats == 1); bus.RID = '0;
                    bus.RRESP  = is_err(rd_addr) ? 2'b10 : 2'b00;
                    bus.RDATA  = (rd_beats == 1) ? (is_err(rd_addr) ? 32'h0 : slave_mem[rd_addr[11:2]])
                                                 : $urandom;
                end
            end
            if (bus.RVALID && bus.RREADY) begin rd_beats--; r_drop = 1; end
            // B channel
            if (b_drop) begin bus.BVALID = 0; b_drop = 0; aw_done = 0; w_done = 0; end
            if (!bus.BVALID && w_done) begin
                if (b_delay > 0) b_delay--;
                else begin
                    bus.BVALID = 1; bus.BID = '0;
                    bus.BRESP  = is_err(wr_addr) ? 2'b10 : 2'b00;
                end
            end
            if (bus.BVALID && bus.BREADY) b_drop = 1;
            // W channel, handled before AW so an early WVALID is caught
            if (prev_w_wait) begin
                chk("w_hold_valid", {31'b0, bus.WVALID}, 32'd1);
                chk("w_hold_data", bus.WDATA, prev_wdata);
            end
            if (bus.WVALID) begin
                chk("w_after_aw", {31'b0, aw_done}, 32'd1);
                bus.WREADY = !w_block && ($urandom_range(0, 2) != 0);
                if (bus.WREADY) begin
                    chk("wlast", {31'b0, bus.WLAST}, 32'd1);
                    chk("wdata", bus.WDATA, cur_wdata);
                    chk("wstrb", {28'b0, bus.WSTRB}, {28'b0, cur_wstrb});
                    if (!is_err(wr_addr))
                        for (int b = 0; b < 4; b++)
                            if (bus.WSTRB[b]) slave_mem[wr_addr[11:2]][8*b +: 8] = bus.WDATA[8*b +: 8];
                    w_done = 1; b_delay = $urandom_range(0, 2);
                end
            end else begin
                bus.WREADY = $urandom_range(0, 1);
            end
            prev_w_wait = bus.WVALID && !bus.WREADY; prev_wdata = bus.WDATA;
            // AW channel
            if (prev_aw_wait) begin
                chk("aw_hold_valid", {31'b0, bus.AWVALID}, 32'd1);
                chk("aw_hold_addr", bus.AWADDR, prev_awaddr);
            end
            bus.AWREADY = ($urandom_range(0, 2) != 0);
            if (bus.AWVALID && bus.AWREADY) begin
                chk("awaddr", bus.AWADDR, cur_addr);
                chk("awlen", {28'b0, bus.AWLEN}, 32'd0);
                chk("awburst", {30'b0, bus.AWBURST}, 32'd1);
                chk("awsize", {29'b0, bus.AWSIZE}, {29'b0, cur_size});
                chk("awid", {28'b0, bus.AWID}, 32'd0);
                aw_done = 1; wr_addr = bus.AWADDR;
            end
            prev_aw_wait = bus.AWVALID && !bus.AWREADY; prev_awaddr = bus.AWADDR;
            // AR channel with optional forced stall
            if (prev_ar_wait) begin
                chk("ar_hold_valid", {31'b0, bus.ARVALID}, 32'd1);
                chk("ar_hold_addr", bus.ARADDR, prev_araddr);
            end
            if (bus.ARVALID && ar_stall > 0) begin
                bus.ARREADY = 0; ar_stall--;
            end else begin
                bus.ARREADY = ($urandom_range(0, 2) != 0);
            end
            if (bus.ARVALID && bus.ARREADY) begin
                chk("araddr", bus.ARADDR, cur_addr);
                chk("arlen", {28'b0, bus.ARLEN}, 32'd0);
                chk("arburst", {30'b0, bus.ARBURST}, 32'd1);
                chk("arsize", {29'b0, bus.ARSIZE}, {29'b0, cur_size});
                chk("arid", {28'b0, bus.ARID}, 32'd0);
                rd_pend = 1; rd_addr = bus.ARADDR; rd_delay = $urandom_range(0, 2);
                rd_beats = ($urandom_range(0, 4) == 0) ? 2 : 1;
            end
            prev_ar_wait = bus.ARVALID && !bus.ARREADY; prev_araddr = bus.ARADDR;
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input logic [3:0] ws, input bit track);
        exp_t e;
        int   n = 0;
        req_valid = 1; req_write = wr; req_addr = a; req_size = sz; req_wdata = wd; req_wstrb = ws;
        while (!req_ready && n < 200) begin @(negedge ACLK); n++; end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL req_accept_timeout: got req_ready=0 required 1 within 200 cycles");
            req_valid = 0;
            return;
        end
        cur_addr = a; cur_size = sz; cur_wdata = wd; cur_wstrb = ws;
        if (track) begin
            e.wr = wr; e.err = is_err(a);
            if (wr) begin
                e.rdata = last_rdata;
                if (!e.err)
                    for (int b = 0; b < 4; b++)
                        if (ws[b]) ref_mem[a[11:2]][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e.rdata = e.err ? 32'h0 : ref_mem[a[11:2]];
                last_rdata = e.rdata;
            end
            sbq.push_back(e);
        end
        @(negedge ACLK);
    endtask

    task automatic idle(input int n);
        req_valid = 0;
        repeat (n) @(negedge ACLK);
    endtask

    task automatic drain(input string name);
        int n = 0;
        req_valid = 0;
        while (sbq.size() > 0 && n < 300) begin @(negedge ACLK); n++; end
        chk(name, sbq.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        logic [3:0]  ws;
        int          n;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = $urandom; slave_mem[i] = ref_mem[i];
        end
        ref_mem[4] = 32'hDEAD_BEEF; slave_mem[4] = 32'hDEAD_BEEF;

        repeat (3) @(negedge ACLK);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_valids", {27'b0, bus.ARVALID, bus.AWVALID, bus.WVALID, bus.RREADY, bus.BREADY}, 32'd0);
        chk("rst_araddr", bus.ARADDR, 32'd0);
        ARESETn = 1;
        idle(2);

        do_req(0, 32'h10, 3'd2, 32'h0, 4'h0, 1);               // word read
        do_req(1, 32'h23, 3'd0, 32'hAB00_0000, 4'b1000, 1);    // byte write
        idle(1);
        ar_stall = 5;
        do_req(0, 32'h100, 3'd2, 32'h0, 4'h0, 1);              // AR backpressure
        do_req(1, 32'h40, 3'd2, 32'h1234_5678, 4'hF, 1);       // back-to-back pair
        do_req(0, 32'h40, 3'd2, 32'h0, 4'h0, 1);
        do_req(1, 32'h900, 3'd2, 32'h5555_AAAA, 4'hF, 1);      // error, then OKAY read
        do_req(0, 32'h44, 3'd2, 32'h0, 4'h0, 1);
        drain("drain_directed");

        for (int k = 0; k < 40; k++) begin
            sz = 3'($urandom_range(0, 2));
            a  = $urandom_range(0, 32'hFFF) & ~((32'd1 << sz) - 32'd1);
            ws = (sz == 3'd0) ? (4'b0001 << a[1:0]) : (sz == 3'd1) ? (4'b0011 << a[1:0]) : 4'hF;
            do_req(1'($urandom_range(0, 1)), a, sz, $urandom, ws, 1);
            n = $urandom_range(0, 2);
            if (n > 0) idle(n);
        end
        drain("drain_random");

        // Abort a write stuck in W by asserting reset.
        w_block = 1;
        do_req(1, 32'h80, 3'd2, 32'hCAFE_F00D, 4'hF, 0);
        req_valid = 0;
        n = 0;
        while (!bus.WVALID && n < 50) begin @(negedge ACLK); n++; end
        chk("reached_w", {31'b0, bus.WVALID}, 32'd1);
        ARESETn = 0;
        #1;
        chk("abort_wvalid", {31'b0, bus.WVALID}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        repeat (3) @(negedge ACLK);
        ARESETn = 1; w_block = 0; last_rdata = '0;
        idle(3);
        do_req(0, 32'h80, 3'd2, 32'h0, 4'h0, 1);
        do_req(0, 32'h10, 3'd2, 32'h0, 4'h0, 1);
        drain("drain_after_abort");
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
